// File: rtl/predistort_taps_ctrl.sv
// ============================================================================
// Module   : predistort_taps_ctrl
// Brief    : Double-banked tap RAM that streams one bank to predistort taps_*.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module predistort_taps_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_stb,
    input  logic             wr_bank,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load_stb,
    input  logic             load_bank,
    output logic [WIDTH-1:0] taps_tdata,
    output logic             taps_tlast,
    output logic             taps_tvalid,
    input  logic             taps_tready,
    output logic             busy,
    output logic             active_bank,
    output logic             wr_err,
    output logic [15:0]      load_count
);

    localparam int              NTAPS     = 1 << DEPTH;
    localparam logic [DEPTH-1:0] LAST_ADDR = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [WIDTH-1:0] mem [0:2*NTAPS-1];

    logic [1:0]       state_q, state_d;
    logic             cur_bank_q, cur_bank_d;
    logic             pend_q, pend_bank_q;
    logic [DEPTH-1:0] rd_addr_q;
    logic [WIDTH-1:0] tdata_q;
    logic             tlast_q, tvalid_q;
    logic             active_bank_q;
    logic [15:0]      load_count_q;
    logic             wr_err_q;

    logic w_fire, w_start, w_busy, w_rd_en, w_done, w_wr_rej;

    assign w_fire   = tvalid_q & taps_tready;
    assign w_start  = (state_q == S_IDLE) & (load_stb | pend_q);
    assign w_wr_rej = wr_stb & w_busy & (wr_bank == cur_bank_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a fresh request in IDLE overrides a pending one
    always_comb begin
        state_d    = state_q;
        cur_bank_d = cur_bank_q;
        case (state_q)
            S_IDLE: begin
                if (load_stb || pend_q) begin
                    state_d    = S_PRIME;
                    cur_bank_d = load_stb ? load_bank : pend_bank_q;
                end
            end
            S_PRIME:  state_d = S_STREAM;
            S_STREAM: if (w_fire && tlast_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_busy  = (state_q != S_IDLE) | pend_q;
        w_rd_en = (state_q == S_PRIME) | ((state_q == S_STREAM) & w_fire & ~tlast_q);
        w_done  = (state_q == S_STREAM) & w_fire & tlast_q;
    end

    always_ff @(posedge clk) begin
        if (!w_wr_rej && wr_stb) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // The output register doubles as the RAM read register, so every accepted
    // beat immediately fetches the next entry and tready-high streams have no gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_bank_q    <= 1'b0;
            pend_q        <= 1'b0;
            pend_bank_q   <= 1'b0;
            rd_addr_q     <= '0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            tvalid_q      <= 1'b0;
            active_bank_q <= 1'b0;
            load_count_q  <= 16'd0;
            wr_err_q      <= 1'b0;
        end else begin
            wr_err_q <= w_wr_rej;
            if (clear) begin
                pend_q   <= 1'b0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end else begin
                cur_bank_q <= cur_bank_d;
                if (load_stb && state_q != S_IDLE) begin
                    pend_q      <= 1'b1;
                    pend_bank_q <= load_bank;
                end else if (w_start) begin
                    pend_q <= 1'b0;
                end
                if (w_start) begin
                    rd_addr_q <= '0;
                end else if (w_rd_en) begin
                    rd_addr_q <= rd_addr_q + DEPTH'(1);
                end
                if (w_rd_en) begin
                    tdata_q  <= mem[{cur_bank_q, rd_addr_q}];
                    tlast_q  <= (rd_addr_q == LAST_ADDR);
                    tvalid_q <= 1'b1;
                end else if (w_done) begin
                    tvalid_q      <= 1'b0;
                    tlast_q       <= 1'b0;
                    active_bank_q <= cur_bank_q;
                    load_count_q  <= load_count_q + 16'd1;
                end
            end
        end
    end

    assign taps_tdata  = tdata_q;
    assign taps_tlast  = tlast_q;
    assign taps_tvalid = tvalid_q;
    assign busy        = w_busy;
    assign active_bank = active_bank_q;
    assign wr_err      = wr_err_q;
    assign load_count  = load_count_q;

endmodule

`default_nettype wire

// File: doc/predistort_taps_ctrl.md
# predistort_taps_ctrl

Tap-table controller for `predistort`. Holds two banks of 2^DEPTH predistortion taps in internal RAM, written at any time through a simple strobe write port. On command, it streams a selected bank into the predistorter's `taps_*` AXI-stream port, asserting tlast on the final entry. Double-banking lets software build a new table while the live one stays intact, then swap with a single load command.

## Interface
- WIDTH, 16, tap word width; must match `predistort` WIDTH
- DEPTH, 7, log2 of taps per bank (128 taps)
- clk  in  1  clock
- reset  in  1  synchronous, active-high; full reset
- clear  in  1  synchronous, active-high; aborts any stream, keeps RAM and active_bank
- wr_stb  in  1  write strobe, one tap per cycle
- wr_bank  in  1  target bank for the write
- wr_addr  in  DEPTH  tap index
- wr_data  in  WIDTH  tap value
- load_stb  in  1  request to stream a bank to the predistorter
- load_bank  in  1  bank to stream
- taps_tdata  out  WIDTH  tap stream data
- taps_tlast  out  1  high on entry 2^DEPTH-1 only
- taps_tvalid  out  1  tap stream valid
- taps_tready  in  1  tap stream ready
- busy  out  1  stream in progress or pending
- active_bank  out  1  bank most recently streamed to completion
- wr_err  out  1  one-cycle pulse: write rejected
- load_count  out  16  completed loads, wraps at 16'hFFFF→0

## Operation
- States:
  - IDLE
  - PRIME: one cycle, RAM read of addr 0
  - STREAM
- IDLE → PRIME on load_stb, or on a pending request. Latch `cur_bank`, then rd_addr=0.
- STREAM: beat k carries bank[cur_bank][k] for k=0…2^DEPTH-1, in order, with no duplicates or drops. Advance on tvalid&tready.
- The final beat's handshake returns the block to IDLE on the next cycle. On that same edge:
  - active_bank←cur_bank
  - load_count+1
- Pending: a load_stb while not IDLE sets `pend`/`pend_bank`. If several arrive, the last one wins; it is one-deep. From IDLE with pend set, the block enters PRIME and clears pend.
- A load_stb on the same cycle as the final handshake is captured as pending.
- Writes:
  - Accepted unconditionally, except when busy and wr_bank==cur_bank.
  - A rejected write leaves RAM unchanged and pulses wr_err the next cycle.
  - Writes to active_bank while IDLE are accepted; they take effect in the predistorter only after a reload.
- Output holding: tdata, tlast and tvalid hold stable while tvalid&!tready. Use a prefetch/skid register so that a 1-cycle RAM read never causes a bubble while tready stays high.
- clear: next cycle tvalid=0, tlast=0, state IDLE, pend=0. The current stream is dropped without tlast; `predistort` must be cleared alongside. RAM, active_bank and load_count are unchanged.
- reset: clear plus active_bank=0, load_count=0. RAM is not reset.

## Timing
- Reset values:
  - taps_tvalid=0, taps_tlast=0
  - busy=0, active_bank=0
  - wr_err=0, load_count=0
  - taps_tdata=0
- Cycle numbering: load_stb sampled in IDLE at edge N.
  - PRIME during cycle N+1.
  - taps_tvalid first high with entry 0 at N+2.
- With tready held high, the last beat handshakes at N+1+2^DEPTH, and busy falls at N+2+2^DEPTH.
- busy rises at N+1.
- A pending load starts PRIME one cycle after returning to IDLE.
- Write latency is 1 cycle: a write at edge M is visible to a read at edge M+1.
- wr_err pulses at M+1.

## Test plan
- Bank load: write bank0 addr i = 16'h1000+i for i=0…127, load_stb bank0, tready=1.
  - tvalid from N+2 to N+129, data 1000…107F, tlast only on 107F.
  - busy low at N+130, active_bank=0, load_count=1.
- Backpressure: same load with tready alternating 1,0.
  - Exactly 128 beats in order.
  - tdata/tlast stable during every stall.
- Write conflict: during a bank0 stream, write bank0 addr 5 = 16'hDEAD and bank1 addr 5 = 16'hBEEF.
  - wr_err pulses once.
  - A later bank0 stream shows 1005; a bank1 stream shows BEEF at beat 5.
- Pending: load_stb bank1 from IDLE, then load_stb bank0 and load_stb bank1 while busy.
  - Exactly two streams, both from bank1.
  - load_count=2, active_bank=1.
- Clear at beat 40: tvalid low the next cycle, busy=0, pending dropped, load_count unchanged. A subsequent load streams all 128 entries.
- Reset mid-stream with active_bank=1 and load_count=3: all outputs take their reset values, active_bank=0, load_count=0. RAM is intact: a following load of bank0 reproduces 1000…107F.
